// File: rtl/uart_rx_pkg.sv
// Shared constants and state encoding for the UART receiver.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned START_BITS = 1;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_VALID  = 3'd5
  } rx_state_t;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_fsm.sv
// Frame sequencer for the UART receiver: start detect, per-bit strobes, frame accept.
module uart_rx_fsm #(
  parameter int unsigned Prescale_Width = 6,
  parameter int unsigned DATA_BITS      = uart_rx_pkg::DATA_BITS
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [Prescale_Width-1:0] Prescale,
  input  logic [3:0]                bit_cnt,
  input  logic [Prescale_Width-1:0] edge_cnt,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic                      enable,
  output logic                      dat_samp_en,
  output logic                      deser_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      data_valid,
  output logic                      busy
);

  import uart_rx_pkg::*;

  // bit_cnt index of the start bit, last data bit and the parity slot
  localparam logic [BIT_CNT_W-1:0] START_IDX = BIT_CNT_W'(0);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(START_BITS + DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] PAR_IDX   = BIT_CNT_W'(START_BITS + DATA_BITS);

  rx_state_t r_state;
  rx_state_t w_next;
  logic      r_par_en_q;
  logic      r_par_err_q;

  logic                 w_bit_end;
  logic                 w_enter_start;
  logic [BIT_CNT_W-1:0] w_stop_idx;

  assign w_bit_end     = (edge_cnt == (Prescale - Prescale_Width'(1)));
  assign w_stop_idx    = r_par_en_q ? (PAR_IDX + BIT_CNT_W'(1)) : PAR_IDX;
  assign w_enter_start = (w_next == ST_START) && (r_state != ST_START);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Frame-scoped flags: parity enable latched at frame start, sticky parity error
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_en_q  <= 1'b0;
      r_par_err_q <= 1'b0;
    end else if (w_enter_start) begin
      r_par_en_q  <= PAR_EN;
      r_par_err_q <= 1'b0;
    end else if ((r_state == ST_PARITY) && w_bit_end) begin
      r_par_err_q <= r_par_err_q | par_err;
    end
  end

  // Next-state: advance only at bit_end; a bit_cnt that disagrees with the state aborts
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!RX_IN) w_next = ST_START;
      end
      ST_START: begin
        if (w_bit_end) begin
          if ((bit_cnt != START_IDX) || strt_glitch) w_next = ST_IDLE;
          else                                       w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (bit_cnt == DATA_LAST)                          w_next = r_par_en_q ? ST_PARITY : ST_STOP;
          else if ((bit_cnt == START_IDX) || (bit_cnt > DATA_LAST)) w_next = ST_IDLE;
          else                                               w_next = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          if ((bit_cnt == PAR_IDX) && r_par_en_q) w_next = ST_STOP;
          else                                    w_next = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if ((bit_cnt == w_stop_idx) && !stp_err && !r_par_err_q) w_next = ST_VALID;
          else                                                      w_next = ST_IDLE;
        end
      end
      ST_VALID: begin
        w_next = RX_IN ? ST_IDLE : ST_START;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from state and bit_end; strobes land on the last cycle of their bit
  always_comb begin
    enable      = 1'b0;
    dat_samp_en = 1'b0;
    busy        = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (r_state)
      ST_START: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        busy        = 1'b1;
        strt_chk_en = w_bit_end;
      end
      ST_DATA: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        busy        = 1'b1;
        deser_en    = w_bit_end;
      end
      ST_PARITY: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        busy        = 1'b1;
        par_chk_en  = w_bit_end;
      end
      ST_STOP: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        busy        = 1'b1;
        stp_chk_en  = w_bit_end;
      end
      ST_VALID: begin
        data_valid  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule : uart_rx_fsm

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm with a behavioural edge/bit counter.
module tb_uart_rx_fsm;

  localparam int unsigned PW = 6;
  localparam int unsigned NB = 8;

  logic          clk;
  logic          rst_n;
  logic          rx_in;
  logic          par_en;
  logic [PW-1:0] prescale;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] edge_cnt;
  logic          strt_glitch, par_err, stp_err;
  logic          enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic          data_valid, busy;

  uart_rx_fsm #(.Prescale_Width(PW), .DATA_BITS(NB)) dut (
    .CLK(clk), .RST(rst_n), .RX_IN(rx_in), .PAR_EN(par_en), .Prescale(prescale),
    .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .enable(enable), .dat_samp_en(dat_samp_en),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge/bit counter: counts oversampling edges while enabled, clears otherwise
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == prescale - PW'(1)) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + PW'(1);
    end
  end

  typedef struct {
    int p; bit pe; bit glitch; bit perr; bit serr; bit flip;
    int e_dv; int e_deser; int e_busy; int e_par_at; int e_stp_at;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // observation results
  int n_deser, n_busy, n_en, n_samp, n_dv, n_misplaced;
  int dv_first, dv_second, strt_at, par_at, stp_at;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Expected frame behaviour from frame-format rules
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   len;
    r   = v;
    len = (1 + NB + int'(v.pe) + 1) * v.p;
    if (v.glitch) begin
      r.e_dv = -1; r.e_deser = 0; r.e_busy = v.p; r.e_par_at = -1; r.e_stp_at = -1;
    end else begin
      r.e_deser  = NB;
      r.e_busy   = len;
      r.e_par_at = v.pe ? (1 + NB + 1) * v.p - 1 : -1;
      r.e_stp_at = len - 1;
      r.e_dv     = (v.serr || (v.pe && v.perr)) ? -1 : len;
    end
    return r;
  endfunction

  // Watch ncyc cycles starting with the first START cycle; optionally restart in VALID
  task automatic observe(input int p, input int ncyc, input bit b2b, input bit flip);
    int base;
    bit restarted;
    n_deser = 0; n_busy = 0; n_en = 0; n_samp = 0; n_dv = 0; n_misplaced = 0;
    dv_first = -1; dv_second = -1; strt_at = -1; par_at = -1; stp_at = -1;
    base = 0; restarted = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (deser_en) begin
        n_deser++;
        if (((i - base + 1) % p != 0) || ((i - base + 1) / p - 1 < 1) ||
            ((i - base + 1) / p - 1 > NB)) n_misplaced++;
      end
      if (busy)        n_busy++;
      if (enable)      n_en++;
      if (dat_samp_en) n_samp++;
      if (strt_chk_en && strt_at < 0) strt_at = i;
      if (par_chk_en  && par_at  < 0) par_at  = i;
      if (stp_chk_en  && stp_at  < 0) stp_at  = i;
      if (data_valid) begin
        n_dv++;
        if (dv_first < 0) dv_first = i;
        else if (dv_second < 0) dv_second = i;
      end
      if (i == 0) begin
        rx_in = 1'b1;
        if (flip) par_en = ~par_en;
      end else if (rx_in == 1'b0) begin
        rx_in = 1'b1;
      end
      if (b2b && data_valid && !restarted) begin
        rx_in = 1'b0;
        restarted = 1'b1;
        base = i + 1;
      end
    end
  endtask

  task automatic launch(input vec_t v);
    @(negedge clk);
    prescale    = PW'(v.p);
    par_en      = v.pe;
    strt_glitch = v.glitch;
    par_err     = v.perr;
    stp_err     = v.serr;
    rx_in       = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    launch(v);
    observe(v.p, v.e_busy + 10, 1'b0, v.flip);
    check({tag, "_dv_cnt"},   n_dv, (v.e_dv < 0) ? 0 : 1);
    check({tag, "_dv_at"},    dv_first, v.e_dv);
    check({tag, "_deser"},    n_deser, v.e_deser);
    check({tag, "_deser_pos"}, n_misplaced, 0);
    check({tag, "_busy"},     n_busy, v.e_busy);
    check({tag, "_enable"},   n_en, v.e_busy);
    check({tag, "_samp"},     n_samp, v.e_busy);
    check({tag, "_strt_at"},  strt_at, v.p - 1);
    check({tag, "_par_at"},   par_at, v.e_par_at);
    check({tag, "_stp_at"},   stp_at, v.e_stp_at);
    repeat (4) @(negedge clk);
  endtask

  function automatic int outs();
    return int'({enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                 stp_chk_en, data_valid, busy});
  endfunction

  vec_t tbl [8];
  vec_t v;
  bit   found;
  int   plist [3];

  initial begin
    //      p  pe gl pe se fl   dv  deser busy par  stp
    tbl[0] = '{8,  0, 0, 0, 0, 0,  80, 8, 80,  -1,  79};
    tbl[1] = '{16, 1, 0, 0, 0, 0, 176, 8, 176, 159, 175};
    tbl[2] = '{8,  0, 1, 0, 0, 0,  -1, 0, 8,   -1,  -1};
    tbl[3] = '{8,  1, 0, 1, 0, 0,  -1, 8, 88,  79,  87};
    tbl[4] = '{8,  0, 0, 0, 1, 0,  -1, 8, 80,  -1,  79};
    tbl[5] = '{32, 1, 0, 0, 0, 1, 352, 8, 352, 319, 351};
    tbl[6] = '{16, 0, 0, 1, 0, 1, 160, 8, 160, -1,  159};
    tbl[7] = '{32, 0, 0, 0, 0, 0, 320, 8, 320, -1,  319};
    plist[0] = 8; plist[1] = 16; plist[2] = 32;

    rst_n = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = PW'(8);
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    #12;
    check("reset_outs", outs(), 0);
    @(negedge clk);
    rx_in = 1'b0;
    @(negedge clk);
    check("reset_hold_outs", outs(), 0);
    rx_in = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outs", outs(), 0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // back-to-back frames, restart during VALID
    v = model('{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    launch(v);
    observe(8, 2 * 80 + 12, 1'b1, 1'b0);
    check("b2b_dv_cnt", n_dv, 2);
    check("b2b_dv1_at", dv_first, 80);
    check("b2b_dv2_at", dv_second, 161);
    check("b2b_deser", n_deser, 16);
    check("b2b_deser_pos", n_misplaced, 0);
    check("b2b_busy", n_busy, 160);
    repeat (4) @(negedge clk);

    // reset in the middle of data bit 4
    v = model('{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    launch(v);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      rx_in = 1'b1;
      if (bit_cnt == 4'd4 && edge_cnt == PW'(3)) found = 1'b1;
    end
    check("rst_mid_reach", int'(found), 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_outs", outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_dv = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (data_valid || busy) n_dv++;
    end
    check("rst_mid_quiet", n_dv, 0);
    run_vec("post_rst", v);

    // randomized frames against the reference model
    for (int i = 0; i < 12; i++) begin
      v.p      = plist[$urandom_range(0, 2)];
      v.pe     = 1'($urandom_range(0, 1));
      v.glitch = ($urandom_range(0, 5) == 0);
      v.perr   = ($urandom_range(0, 3) == 0);
      v.serr   = ($urandom_range(0, 3) == 0);
      v.flip   = 1'($urandom_range(0, 1));
      v = model(v);
      run_vec($sformatf("rnd%0d", i), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_fsm
